// File: rtl/vga_filter_out.sv
// VGA output stage: per-frame filter select on the frame-buffer pixel, sync/blank
// delay matched to the frame-buffer read latency, and registered VGA pins.
module vga_filter_out #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [11:0] pix_raw,
  input  logic [11:0] pix_grey,
  input  logic [1:0]  filt_req,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [1:0]  filt_act,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    FILT_BYPASS   = 2'b00,
    FILT_GREY     = 2'b01,
    FILT_INV      = 2'b10,
    FILT_INV_GREY = 2'b11
  } filt_e;

  logic [LAT-1:0] hs_d;
  logic [LAT-1:0] vs_d;
  logic           vs_prev;
  logic           frame_start;
  logic           blank_sel;
  logic [11:0]    pix_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_d <= '1;
      vs_d <= '1;
    end else begin
      hs_d[0] <= hsync_in;
      vs_d[0] <= vsync_in;
      for (int unsigned i = 1; i < LAT; i++) begin
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
      end
    end
  end

  assign vga_hs = hs_d[LAT-1];
  assign vga_vs = vs_d[LAT-1];

  // Blank is consumed one stage early by the RGB register, so its final stage is never kept.
  if (LAT == 1) begin : g_bl_direct
    assign blank_sel = blank_in;
  end else begin : g_bl_pipe
    logic [LAT-2:0] bl_d;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bl_d <= '1;
      end else begin
        bl_d[0] <= blank_in;
        for (int unsigned i = 1; i < LAT - 1; i++) begin
          bl_d[i] <= bl_d[i-1];
        end
      end
    end
    assign blank_sel = bl_d[LAT-2];
  end

  assign frame_start = vs_prev & ~vsync_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev   <= 1'b1;
      filt_act  <= FILT_BYPASS;
      frame_cnt <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (frame_start) begin
        filt_act  <= filt_req;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    pix_sel = pix_raw;
    case (filt_act)
      FILT_BYPASS:   pix_sel = pix_raw;
      FILT_GREY:     pix_sel = pix_grey;
      FILT_INV:      pix_sel = ~pix_raw;
      FILT_INV_GREY: pix_sel = ~pix_grey;
      default:       pix_sel = pix_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || blank_sel) begin
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      {vga_r, vga_g, vga_b} <= pix_sel;
    end
  end

endmodule

// File: doc/vga_filter_out.md
# vga_filter_out

Output stage of the video path, directly downstream of the greyscale filter. Takes the raw frame-buffer pixel and the filtered (greyscale) pixel, selects the displayed version per frame, delays the VGA sync/blank controls to match the frame-buffer read latency, and drives the registered VGA pins. Filter changes requested from the switches take effect only at the start of a vertical sync pulse, so a frame is never split between two filters.

## Interface
- `LAT`, default 2: total control-to-pin latency in cycles; legal range 1..8. The frame-buffer read latency is `LAT-1`.
- `clk` in 1: pixel clock.
- `rst_n` in 1: synchronous, active-low reset.
- `hsync_in` in 1: horizontal sync from the timing generator; active-low.
- `vsync_in` in 1: vertical sync from the timing generator; active-low.
- `blank_in` in 1: 1 outside the visible area.
- `pix_raw` in 12: RGB444 `{R[11:8],G[7:4],B[3:0]}` from the frame buffer.
- `pix_grey` in 12: greyscale version of `pix_raw` from the greyscale filter; combinational, same cycle as `pix_raw`.
- `filt_req` in 2: requested filter.
  - 00: bypass
  - 01: grey
  - 10: invert
  - 11: inverted grey
- `vga_r`, `vga_g`, `vga_b` out 4 each: registered colour outputs.
- `vga_hs`, `vga_vs` out 1 each: registered, delayed syncs.
- `filt_act` out 2: filter currently applied.
- `frame_cnt` out 8: count of frame starts; wraps around.

## Operation
- Alignment: controls presented at cycle t belong to the pixel on `pix_raw`/`pix_grey` at cycle t+LAT-1. All outputs for that pixel appear at cycle t+LAT.
- Control delay line:
  - Shift registers of depth `LAT` carry hsync, vsync and blank.
  - Stage reset values: hsync=1, vsync=1, blank=1.
- Frame start is a falling edge of `vsync_in`: the previous sampled value was 1 and the current value is 0.
  - Edge-detect register resets to 1, so the first cycle out of reset never produces a false edge.
- On frame start:
  - `filt_act` <= `filt_req`.
  - `frame_cnt` <= `frame_cnt`+1, modulo 256 (255 -> 0).
- `filt_req` changes at any other time are ignored until the next frame start.
- Pixel select:
  - 00: `pix_raw`
  - 01: `pix_grey`
  - 10: bitwise NOT of `pix_raw`
  - 11: bitwise NOT of `pix_grey`
- Output register: `{vga_r,vga_g,vga_b}` <= 12'h000 if the blank bit at stage `LAT-1` is 1, else the selected pixel. For `LAT`=1, "stage `LAT-1`" means `blank_in` itself.
- `filt_act` is applied combinationally at pixel-select time.
  - A mode change lands during vsync, which is blanked, so no visible pixel mixes modes.
- Reset (`rst_n`=0 at a rising edge) forces all of the following on the next edge, at any time, including mid-frame:
  - all delay stages to their reset values
  - RGB outputs = 0
  - `vga_hs`=`vga_vs`=1
  - `filt_act`=00
  - `frame_cnt`=0
  - edge register = 1
- Reset has priority over a coincident frame-start edge.
- Width rules:
  - NOT is applied to all 12 bits; no arithmetic on pixels.
  - `frame_cnt` is an 8-bit unsigned wrap.

## Timing
- Latency: `vga_hs`/`vga_vs` equal `hsync_in`/`vsync_in` delayed exactly `LAT` cycles; blanking of RGB follows the same delay.
- `filt_act` and `frame_cnt` update on the edge after the cycle in which `vsync_in` is first seen low; that is 1 cycle after the falling edge appears at the input.
- Throughput: one pixel per clock, no stalls, no handshake.
- Reset values, all outputs: `vga_r`/`vga_g`/`vga_b`=0, `vga_hs`=1, `vga_vs`=1, `filt_act`=0, `frame_cnt`=0.
- After reset release, outputs are driven from reset-valued stages for `LAT` cycles. RGB stays 0 throughout because the blank stages are 1.

## Test plan
- Reset and latency, `LAT`=2:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release. Pulse `hsync_in` low at cycle 10 for 5 cycles.
  - Required: during reset, RGB=0, hs/vs=1, `filt_act`=0, `frame_cnt`=0. `vga_hs` goes low at cycle 12 and stays low for exactly 5 cycles.
- Bypass and blanking:
  - Stimulus: `filt_act`=00, `blank_in`=0, `pix_raw`=12'hA5C at cycle t+1 for controls at t.
  - Required: RGB={A,5,C} at t+2. With `blank_in`=1 at t, RGB=0 at t+2.
- Mode latch:
  - Stimulus: set `filt_req`=10 mid-frame.
  - Required: `filt_act` stays 00 until the `vsync_in` falling edge, then becomes 10 one cycle later. With `pix_raw`=12'h0F3, the next visible pixel shows 12'hF0C.
- Grey modes:
  - Stimulus: `pix_grey`=12'h777; mode 01, then mode 11.
  - Required: mode 01 gives 12'h777; mode 11 gives 12'h888.
- Frame counter wrap:
  - Stimulus: apply 257 vsync falling edges.
  - Required: `frame_cnt` reads 255 after edge 255, 0 after edge 256, 1 after edge 257.
- Reset mid-operation and priority:
  - Stimulus: assert `rst_n`=0 in the same cycle the vsync edge is detected, with `filt_req`=11 and `frame_cnt`=5.
  - Required: next cycle `filt_act`=0 and `frame_cnt`=0. Repeat with `LAT`=1 and `LAT`=8 for the latency checks.
